// File: rtl/param_regfile.sv
// Multi-entry register file: one write port, two combinational read ports,
// optional hardwired-zero entry 0 and same-cycle write-to-read bypass.
module param_regfile #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_zero;

  assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (w_enable && !w_zero) begin
      mem[w_addr] <= data_in;
    end
  end

  // Reset forces 0, zero register beats bypass, bypass beats stored value.
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] v;
    v = mem[addr];
    if (!rst) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && w_enable && (w_addr == addr)) begin
      v = data_in;
    end
    return v;
  endfunction

  always_comb begin
    data_out_a = rd(r_addr_a);
  end

  always_comb begin
    data_out_b = rd(r_addr_b);
  end

endmodule
